// File: rtl/priority_req_servicer.sv
// rtl/priority_req_servicer.sv - sticky request collector and grant sequencer around priority_circuit
module priority_req_servicer #(
    parameter int WIDTH       = 8,
    parameter int CODE_W      = 3,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req_in,
    output logic [WIDTH-1:0]  pend_out,
    input  logic [WIDTH-1:0]  h_in,
    input  logic              idle_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CODE_W-1:0] code_out,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy_out
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   grant_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [CODE_W-1:0]  code;
    logic               h_any;
    logic               accept;
    logic               timeout;
    logic [WIDTH-1:0]   clr_mask;

    // Scan upward so the highest set bit wins even if h_in is multi-hot.
    always_comb begin
        code  = '0;
        h_any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (h_in[i]) begin
                code  = CODE_W'(i);
                h_any = 1'b1;
            end
        end
    end

    assign accept   = (state == VALID) && valid_out && ready_in;
    assign timeout  = (state == VALID) && !accept && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign clr_mask = (accept || timeout) ? grant_q : '0;
    assign busy_out = (state != IDLE) || (pend_out != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_out   <= '0;
            grant_q    <= '0;
            tmo_cnt    <= '0;
            code_out   <= '0;
            valid_out  <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            // A request arriving while its grant clears stays pending.
            pend_out   <= (pend_out & ~clr_mask) | req_in;
            drop_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!idle_in && h_any) begin
                        grant_q   <= h_in;
                        code_out  <= code;
                        valid_out <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= VALID;
                    end
                end
                VALID: begin
                    if (accept) begin
                        valid_out <= 1'b0;
                        grant_q   <= '0;
                        state     <= IDLE;
                    end else if (timeout) begin
                        valid_out  <= 1'b0;
                        grant_q    <= '0;
                        drop_pulse <= 1'b1;
                        if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
